// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, 1-entry skid buffer,
// synchronous flush for branch squash and a saturating backpressure counter.
module id_ex_pipe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_dsel,
    input  logic [DATA_W-1:0] in_signext,
    input  logic [DATA_W-1:0] in_abus,
    input  logic [DATA_W-1:0] in_bbus,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dsel,
    output logic [DATA_W-1:0] out_signext,
    output logic [DATA_W-1:0] out_abus,
    output logic [DATA_W-1:0] out_bbus,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] dsel;
        logic [DATA_W-1:0] signext;
        logic [DATA_W-1:0] abus;
        logic [DATA_W-1:0] bbus;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    stage_t            main_q, main_d;
    stage_t            skid_q, skid_d;
    stage_t            in_pkt;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              main_load;

    assign in_pkt = '{dsel: in_dsel, signext: in_signext, abus: in_abus,
                      bbus: in_bbus, ctrl: in_ctrl};

    // Flush kills the same-cycle input even when in_ready is high.
    assign accept    = in_valid & in_ready_q & ~flush;
    assign main_load = ~main_valid_q | out_ready;

    // Next-state: main/skid steering, flush squash, stall counting
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        stall_cnt_d  = stall_cnt_q;

        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d.ctrl  = '0;
        end else if (main_load) begin
            if (skid_valid_q) begin
                // Skid drains first to keep FIFO order; a new input refills it.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
                if (accept) begin
                    skid_d       = in_pkt;
                    skid_valid_d = 1'b1;
                end
            end else if (accept) begin
                main_d       = in_pkt;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
                main_d.ctrl  = '0;
            end
        end else if (accept) begin
            skid_d       = in_pkt;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_dsel    = main_q.dsel;
    assign out_signext = main_q.signext;
    assign out_abus    = main_q.abus;
    assign out_bbus    = main_q.bbus;
    assign out_ctrl    = main_q.ctrl;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: default-width instance plus a narrow
// instance (16/4/3) for parameter pass-through and counter saturation.
module tb_id_ex_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_dsel, in_signext, in_abus, in_bbus;
    logic [31:0] out_dsel, out_signext, out_abus, out_bbus;
    logic [9:0]  in_ctrl, out_ctrl;
    logic [15:0] stall_cnt;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [15:0] s_in_dsel, s_in_signext, s_in_abus, s_in_bbus;
    logic [15:0] s_out_dsel, s_out_signext, s_out_abus, s_out_bbus;
    logic [3:0]  s_in_ctrl, s_out_ctrl;
    logic [2:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dsel(in_dsel), .in_signext(in_signext), .in_abus(in_abus), .in_bbus(in_bbus),
        .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dsel(out_dsel), .out_signext(out_signext), .out_abus(out_abus), .out_bbus(out_bbus),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    id_ex_pipe_stage #(.DATA_W(16), .CTRL_W(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_dsel(s_in_dsel), .in_signext(s_in_signext), .in_abus(s_in_abus), .in_bbus(s_in_bbus),
        .in_ctrl(s_in_ctrl), .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_dsel(s_out_dsel), .out_signext(s_out_signext), .out_abus(s_out_abus), .out_bbus(s_out_bbus),
        .out_ctrl(s_out_ctrl), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] dsel, input logic [31:0] abus,
                         input logic [31:0] bbus, input logic [9:0] ctrl);
        in_valid   = v;
        in_dsel    = dsel;
        in_abus    = abus;
        in_bbus    = bbus;
        in_signext = dsel ^ 32'hFFFF_0000;
        in_ctrl    = ctrl;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h99, 32'h99, 32'h99, 10'h3FF);
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        s_in_dsel = '0; s_in_signext = '0; s_in_abus = '0; s_in_bbus = '0; s_in_ctrl = '0;

        // Power-on reset; the presented input must be ignored
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_ctrl",  32'(out_ctrl),  32'h0);
        check("rst_out_abus",  out_abus,       32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        rst_n = 1'b1;

        // Passthrough, back-to-back
        out_ready = 1'b1;
        drive(1'b1, 32'h1, 32'h11, 32'h0, 10'h3FF);
        tick();
        check("pt_abus0",  out_abus,        32'h11);
        check("pt_valid0", 32'(out_valid),  32'h1);
        check("pt_ctrl0",  32'(out_ctrl),   32'h3FF);
        check("pt_sext0",  out_signext,     32'hFFFF_0001);
        drive(1'b1, 32'h2, 32'h22, 32'h0, 10'h3FF);
        tick();
        check("pt_abus1",  out_abus,        32'h22);
        check("pt_rdy1",   32'(in_ready),   32'h1);
        drive(1'b1, 32'h3, 32'h33, 32'h0, 10'h3FF);
        tick();
        check("pt_abus2",  out_abus,        32'h33);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick();
        check("pt_bubble_valid", 32'(out_valid), 32'h0);
        check("pt_bubble_ctrl",  32'(out_ctrl),  32'h0);
        check("pt_stall",        32'(stall_cnt), 32'h0);

        // Backpressure: A in main, B in skid
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h0, 32'hA, 10'h001);
        tick();
        check("bp_A_bbus",  out_bbus,       32'hA);
        check("bp_A_rdy",   32'(in_ready),  32'h1);
        check("bp_A_stall", 32'(stall_cnt), 32'h0);
        drive(1'b1, 32'h2, 32'h0, 32'hB, 10'h002);
        tick();
        check("bp_B_rdy",   32'(in_ready),  32'h0);
        check("bp_hold",    out_bbus,       32'hA);
        check("bp_stall1",  32'(stall_cnt), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick(); tick(); tick();
        check("bp_stall4",  32'(stall_cnt), 32'h4);
        check("bp_hold4",   out_bbus,       32'hA);
        check("bp_hold4_d", out_dsel,       32'h1);

        // Drain + present C while skid is full: C must wait a cycle
        out_ready = 1'b1;
        drive(1'b1, 32'h3, 32'h0, 32'hC, 10'h004);
        tick();
        check("dr_B_bbus",  out_bbus,       32'hB);
        check("dr_B_ctrl",  32'(out_ctrl),  32'h002);
        check("dr_B_rdy",   32'(in_ready),  32'h1);
        check("dr_stall",   32'(stall_cnt), 32'h4);
        tick();
        check("dr_C_bbus",  out_bbus,       32'hC);
        check("dr_C_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick();
        check("dr_empty",   32'(out_valid), 32'h0);

        // Flush with main and skid full and a simultaneous input
        out_ready = 1'b0;
        drive(1'b1, 32'h3, 32'h0, 32'hD, 10'h010);
        tick();
        drive(1'b1, 32'h4, 32'h0, 32'hE, 10'h020);
        tick();
        check("fl_full_rdy", 32'(in_ready), 32'h0);
        check("fl_stall5",   32'(stall_cnt), 32'h5);
        flush = 1'b1;
        drive(1'b1, 32'h5, 32'h0, 32'hF, 10'h040);
        tick();
        check("fl_valid",  32'(out_valid), 32'h0);
        check("fl_ctrl",   32'(out_ctrl),  32'h0);
        check("fl_rdy",    32'(in_ready),  32'h1);
        check("fl_dhold",  out_dsel,       32'h3);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick();
        check("fl_no5_valid", 32'(out_valid), 32'h0);
        tick();
        check("fl_no5_valid2", 32'(out_valid), 32'h0);
        check("fl_no5_dsel",   out_dsel,       32'h3);

        // Reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, 32'h6, 32'h66, 32'h66, 10'h080);
        tick();
        drive(1'b1, 32'h7, 32'h67, 32'h67, 10'h100);
        tick(); tick();
        check("rs_full_rdy", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        tick();
        check("rs_valid", 32'(out_valid), 32'h0);
        check("rs_dsel",  out_dsel,       32'h0);
        check("rs_abus",  out_abus,       32'h0);
        check("rs_ctrl",  32'(out_ctrl),  32'h0);
        check("rs_stall", 32'(stall_cnt), 32'h0);
        check("rs_rdy",   32'(in_ready),  32'h1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h8, 32'h77, 32'h0, 10'h155);
        tick();
        check("rs_next_abus",  out_abus,       32'h77);
        check("rs_next_ctrl",  32'(out_ctrl),  32'h155);
        check("rs_next_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick();
        check("rs_next_empty", 32'(out_valid), 32'h0);

        // Narrow instance: field pass-through and 3-bit counter saturation
        s_in_valid = 1'b1;
        s_in_dsel = 16'hBEEF; s_in_signext = 16'h8001; s_in_abus = 16'h1234;
        s_in_bbus = 16'hFFFF; s_in_ctrl = 4'hA;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sw_dsel",  32'(s_out_dsel),    32'hBEEF);
        check("sw_sext",  32'(s_out_signext), 32'h8001);
        check("sw_abus",  32'(s_out_abus),    32'h1234);
        check("sw_bbus",  32'(s_out_bbus),    32'hFFFF);
        check("sw_ctrl",  32'(s_out_ctrl),    32'hA);
        check("sw_stall", 32'(s_stall_cnt),   32'h7);
        s_out_ready = 1'b1;
        tick();
        check("sw_drain_valid", 32'(s_out_valid), 32'h0);
        check("sw_drain_ctrl",  32'(s_out_ctrl),  32'h0);
        check("sw_stall_keep",  32'(s_stall_cnt), 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
